mips_control_unit: RTL and testbench
====================================

# mips_control_unit

Single-cycle execute/control block of the MIPS core. Each cycle it:
- decodes the instruction fields the core splits out of the current instruction word;
- reads and writes a 32×32-bit general-purpose register file;
- performs the ALU operation;
- reports a PC offset for taken branches and a sticky halt flag.

The core adds the reported offset to its PC, or adds 4 when the offset is zero. The block has no data-memory path, so loads and stores are out of scope.

## Interface
Parameters: none.
- clk  in  1  sole clock; all state updates on rising edge
- rst_b  in  1  synchronous reset, active-high (asserted = 1, sampled on rising clk)
- opcode  in  6  instruction bits [31:26]
- func  in  6  instruction bits [5:0]
- rs_num  in  5  source register index, bits [25:21]
- rt_num  in  5  second source / I-type destination, bits [20:16]
- rd_num  in  5  R-type destination, bits [15:11]
- sh_amount  in  5  shift amount, bits [10:6]
- imm  in  16  immediate, bits [15:0]
- pc_branch  out  16  byte offset added to PC; 0 = no branch (core then adds 4)
- halted_signal  out  1  registered sticky halt flag

## Operation
- Register file regs[0:31], 32 bits each. Reads are combinational. Register 0 always reads 0 and ignores writes.
- Result operands:
  - rs = regs[rs_num], rt = regs[rt_num].
  - simm = sign-extended imm; zimm = zero-extended imm.
- R-type (opcode 0x00), result written to rd_num:
  - 0x20 add, 0x21 addu: rs+rt
  - 0x22 sub, 0x23 subu: rs−rt
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor
  - 0x2A slt (signed), 0x2B sltu (unsigned): result 1 or 0
  - 0x00 sll, 0x02 srl, 0x03 sra: rt shifted by sh_amount
  - 0x04 sllv, 0x06 srlv, 0x07 srav: rt shifted by rs[4:0]
  - 0x0C syscall: halt, no write
  - any other func: no-op
- I-type, result written to rt_num:
  - 0x08 addi, 0x09 addiu: rs+simm
  - 0x0A slti: signed rs<simm; 0x0B sltiu: unsigned rs<simm
  - 0x0C andi, 0x0D ori, 0x0E xori: with zimm
  - 0x0F lui: {imm,16'h0}
- Arithmetic width and overflow:
  - All arithmetic is 32-bit modulo 2^32.
  - add, addi and sub never trap; they wrap exactly like the unsigned variants.
- Branches (no register write):
  - 0x04 beq: rs==rt
  - 0x05 bne: rs!=rt
  - 0x06 blez: signed rs<=0
  - 0x07 bgtz: signed rs>0
- pc_branch is combinational:
  - Branch taken: ({imm[13:0],2'b00} + 16'd4) mod 2^16.
  - Otherwise: 0.
  - If the taken offset wraps to 0 (imm = 0x3FFF), the core falls through to PC+4. This is accepted behaviour.
- Unknown opcodes: no write, pc_branch = 0.
- Halt:
  - A decoded syscall while not halted sets halted_signal to 1 on the next rising edge.
  - halted_signal stays 1 until reset.
  - While halted_signal = 1: no register writes and pc_branch = 0, whatever the instruction.

## Timing
- Zero-latency decode: pc_branch is valid in the same cycle the instruction fields are valid. The core samples it at the next rising edge.
- Register writes commit at the rising edge ending the instruction's cycle. An instruction in the following cycle reads the new value; no forwarding is needed.
- Reset, on a rising edge with rst_b = 1:
  - all regs clear to 0;
  - halted_signal clears to 0;
  - no write from the current instruction.
- pc_branch is forced to 0 while rst_b = 1.
- Reset mid-operation, including while halted, returns the block to the post-reset state in one edge.
- Simultaneous events:
  - A write to register 0 is discarded.
  - An instruction reading the register it writes uses the pre-edge value, e.g. addi r1,r1,1 increments once per cycle.

## Test plan
Inspect regs hierarchically.
- Reset: hold rst_b = 1 for 2 cycles with random fields -> all regs = 0, halted_signal = 0, pc_branch = 0.
- Immediate ops:
  - ori r1,r0,0x00FF -> r1 = 0x000000FF.
  - lui r2,0x8000 -> r2 = 0x80000000.
  - addi r3,r0,0xFFFF -> r3 = 0xFFFFFFFF.
  - Then sltu r4,r1,r3 = 1 and slt r5,r1,r3 = 0.
- Shifts and overflow:
  - sra r6,r2,4 -> 0xF8000000; srl -> 0x08000000.
  - add r7,r2,r2 -> 0x00000000 with no trap.
  - addi r0,r0,5 -> r0 stays 0.
- Branches:
  - beq r1,r1,imm=3 -> pc_branch = 16.
  - bne r1,r1 -> 0.
  - bgtz r3 (negative) -> 0; blez r3 -> (imm<<2)+4.
  - imm = 0x3FFF taken -> pc_branch = 0.
- Halt: syscall -> halted_signal = 1 next edge. A following addi r1,r1,1 leaves r1 unchanged, and a taken beq gives pc_branch = 0. Reset then clears halted_signal.
- Back-to-back: addi r1,r0,1 followed by addi r1,r1,1 on consecutive cycles -> r1 = 2.

Source files
------------

// File: rtl/mips_control_unit.sv
// Single-cycle MIPS execute/control block: decode, 32x32 register file,
// ALU, branch offset generation and a sticky halt flag.
module mips_control_unit (
   input  logic        clk,
   input  logic        rst_b,
   input  logic [5:0]  opcode,
   input  logic [5:0]  func,
   input  logic [4:0]  rs_num,
   input  logic [4:0]  rt_num,
   input  logic [4:0]  rd_num,
   input  logic [4:0]  sh_amount,
   input  logic [15:0] imm,
   output logic [15:0] pc_branch,
   output logic        halted_signal
);

   logic [31:0]        regs_q [0:31];
   logic               halted_q;

   logic [31:0]        rs, rt, simm, zimm;
   logic signed [31:0] rs_s, rt_s;

   logic               wr_en_d;
   logic [4:0]         wr_addr_d;
   logic [31:0]        wr_data_d;
   logic               br_taken_d;
   logic               syscall_d;

   // Register 0 is hard-wired to zero on the read side as well.
   assign rs   = (rs_num == 5'd0) ? 32'd0 : regs_q[rs_num];
   assign rt   = (rt_num == 5'd0) ? 32'd0 : regs_q[rt_num];
   assign rs_s = rs;
   assign rt_s = rt;
   assign simm = {{16{imm[15]}}, imm};
   assign zimm = {16'd0, imm};

   // Decode the instruction fields into a write request, branch decision and syscall.
   always_comb begin
      wr_en_d    = 1'b0;
      wr_addr_d  = rt_num;
      wr_data_d  = 32'd0;
      br_taken_d = 1'b0;
      syscall_d  = 1'b0;
      case (opcode)
         6'h00: begin
            wr_addr_d = rd_num;
            wr_en_d   = 1'b1;
            case (func)
               6'h20, 6'h21: wr_data_d = rs + rt;
               6'h22, 6'h23: wr_data_d = rs - rt;
               6'h24:        wr_data_d = rs & rt;
               6'h25:        wr_data_d = rs | rt;
               6'h26:        wr_data_d = rs ^ rt;
               6'h27:        wr_data_d = ~(rs | rt);
               6'h2A:        wr_data_d = {31'd0, (rs_s < rt_s)};
               6'h2B:        wr_data_d = {31'd0, (rs < rt)};
               6'h00:        wr_data_d = rt << sh_amount;
               6'h02:        wr_data_d = rt >> sh_amount;
               6'h03:        wr_data_d = rt_s >>> sh_amount;
               6'h04:        wr_data_d = rt << rs[4:0];
               6'h06:        wr_data_d = rt >> rs[4:0];
               6'h07:        wr_data_d = rt_s >>> rs[4:0];
               6'h0C: begin
                  wr_en_d   = 1'b0;
                  syscall_d = 1'b1;
               end
               default:      wr_en_d = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin wr_en_d = 1'b1; wr_data_d = rs + simm; end
         6'h0A:        begin wr_en_d = 1'b1; wr_data_d = {31'd0, (rs_s < $signed(simm))}; end
         6'h0B:        begin wr_en_d = 1'b1; wr_data_d = {31'd0, (rs < simm)}; end
         6'h0C:        begin wr_en_d = 1'b1; wr_data_d = rs & zimm; end
         6'h0D:        begin wr_en_d = 1'b1; wr_data_d = rs | zimm; end
         6'h0E:        begin wr_en_d = 1'b1; wr_data_d = rs ^ zimm; end
         6'h0F:        begin wr_en_d = 1'b1; wr_data_d = {imm, 16'd0}; end
         6'h04:        br_taken_d = (rs == rt);
         6'h05:        br_taken_d = (rs != rt);
         6'h06:        br_taken_d = (rs_s <= 32'sd0);
         6'h07:        br_taken_d = (rs_s > 32'sd0);
         default:      ;
      endcase
   end

   // Taken offset wraps modulo 2^16; halt and reset suppress it.
   always_comb begin
      pc_branch = 16'd0;
      if (!rst_b && !halted_q && br_taken_d)
         pc_branch = {imm[13:0], 2'b00} + 16'd4;
   end

   assign halted_signal = halted_q;

   // Register-file writes and sticky halt; reset clears everything in one edge.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
         halted_q <= 1'b0;
      end else if (!halted_q) begin
         if (wr_en_d && (wr_addr_d != 5'd0))
            regs_q[wr_addr_d] <= wr_data_d;
         if (syscall_d)
            halted_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed bench for mips_control_unit: reset, ALU ops, branches, halt.
module tb_mips_control_unit;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [5:0]  opcode, func;
   logic [4:0]  rs_num, rt_num, rd_num, sh_amount;
   logic [15:0] imm;
   logic [15:0] pc_branch;
   logic        halted_signal;

   int checks = 0;
   int errors = 0;

   mips_control_unit dut (
      .clk(clk), .rst_b(rst_b), .opcode(opcode), .func(func),
      .rs_num(rs_num), .rt_num(rt_num), .rd_num(rd_num),
      .sh_amount(sh_amount), .imm(imm),
      .pc_branch(pc_branch), .halted_signal(halted_signal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply fields mid-cycle so they are stable well before the next rising edge.
   task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh,
                        input logic [15:0] im);
      @(negedge clk);
      opcode = op; func = fn; rs_num = rs; rt_num = rt;
      rd_num = rd; sh_amount = sh; imm = im;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rtype(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh);
      instr(6'h00, fn, rs, rt, rd, sh, 16'h0000);
   endtask

   task automatic itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [15:0] im);
      instr(op, 6'h00, rs, rt, 5'd0, 5'd0, im);
   endtask

   initial begin
      rst_b = 1'b1;
      opcode = '0; func = '0; rs_num = '0; rt_num = '0; rd_num = '0; sh_amount = '0; imm = '0;

      // reset with random fields, then a would-be-taken branch
      @(negedge clk);
      opcode = 6'($urandom); func = 6'($urandom); rs_num = 5'($urandom);
      rt_num = 5'($urandom); rd_num = 5'($urandom); sh_amount = 5'($urandom);
      imm = 16'($urandom);
      step();
      instr(6'h04, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'd3);
      chk("pc_in_reset", {16'd0, pc_branch}, 32'd0);
      step();
      for (int i = 0; i < 32; i++) chk($sformatf("reset_r%0d", i), dut.regs_q[i], 32'd0);
      chk("reset_halt", {31'd0, halted_signal}, 32'd0);

      // immediate ops
      @(negedge clk); rst_b = 1'b0;
      itype(6'h0D, 5'd0, 5'd1, 16'h00FF);
      chk("pc_nonbranch", {16'd0, pc_branch}, 32'd0);
      step(); chk("ori_r1", dut.regs_q[1], 32'h000000FF);
      itype(6'h0F, 5'd0, 5'd2, 16'h8000); step(); chk("lui_r2", dut.regs_q[2], 32'h80000000);
      itype(6'h08, 5'd0, 5'd3, 16'hFFFF); step(); chk("addi_r3", dut.regs_q[3], 32'hFFFFFFFF);
      rtype(6'h2B, 5'd1, 5'd3, 5'd4, 5'd0); step(); chk("sltu_r4", dut.regs_q[4], 32'd1);
      rtype(6'h2A, 5'd1, 5'd3, 5'd5, 5'd0); step(); chk("slt_r5", dut.regs_q[5], 32'd0);
      rtype(6'h2A, 5'd3, 5'd1, 5'd23, 5'd0); step(); chk("slt_r23", dut.regs_q[23], 32'd1);

      // shifts and wrap-around arithmetic
      rtype(6'h03, 5'd0, 5'd2, 5'd6, 5'd4); step(); chk("sra_r6", dut.regs_q[6], 32'hF8000000);
      rtype(6'h02, 5'd0, 5'd2, 5'd8, 5'd4); step(); chk("srl_r8", dut.regs_q[8], 32'h08000000);
      rtype(6'h00, 5'd0, 5'd1, 5'd9, 5'd4); step(); chk("sll_r9", dut.regs_q[9], 32'h00000FF0);
      rtype(6'h20, 5'd1, 5'd3, 5'd7, 5'd0); step(); chk("add_r7_wrap", dut.regs_q[7], 32'h000000FE);
      rtype(6'h20, 5'd2, 5'd2, 5'd7, 5'd0); step(); chk("add_r7_ovf", dut.regs_q[7], 32'h00000000);
      rtype(6'h22, 5'd1, 5'd3, 5'd10, 5'd0); step(); chk("sub_r10", dut.regs_q[10], 32'h00000100);
      rtype(6'h24, 5'd1, 5'd3, 5'd11, 5'd0); step(); chk("and_r11", dut.regs_q[11], 32'h000000FF);
      rtype(6'h25, 5'd2, 5'd1, 5'd12, 5'd0); step(); chk("or_r12", dut.regs_q[12], 32'h800000FF);
      rtype(6'h26, 5'd3, 5'd1, 5'd13, 5'd0); step(); chk("xor_r13", dut.regs_q[13], 32'hFFFFFF00);
      rtype(6'h27, 5'd1, 5'd2, 5'd14, 5'd0); step(); chk("nor_r14", dut.regs_q[14], 32'h7FFFFF00);
      rtype(6'h07, 5'd1, 5'd2, 5'd15, 5'd0); step(); chk("srav_r15", dut.regs_q[15], 32'hFFFFFFFF);
      rtype(6'h06, 5'd1, 5'd2, 5'd16, 5'd0); step(); chk("srlv_r16", dut.regs_q[16], 32'h00000001);
      rtype(6'h04, 5'd1, 5'd1, 5'd17, 5'd0); step(); chk("sllv_r17", dut.regs_q[17], 32'h80000000);
      itype(6'h0A, 5'd3, 5'd18, 16'h0000); step(); chk("slti_r18", dut.regs_q[18], 32'd1);
      itype(6'h0B, 5'd1, 5'd19, 16'hFFFF); step(); chk("sltiu_r19", dut.regs_q[19], 32'd1);
      itype(6'h0C, 5'd3, 5'd20, 16'h0F0F); step(); chk("andi_r20", dut.regs_q[20], 32'h00000F0F);
      itype(6'h0E, 5'd3, 5'd21, 16'h00FF); step(); chk("xori_r21", dut.regs_q[21], 32'hFFFFFF00);
      itype(6'h09, 5'd1, 5'd22, 16'hFFFF); step(); chk("addiu_r22", dut.regs_q[22], 32'h000000FE);
      itype(6'h08, 5'd0, 5'd0, 16'd5); step(); chk("r0_stays_0", dut.regs_q[0], 32'd0);
      itype(6'h3F, 5'd0, 5'd1, 16'h1234);
      chk("pc_unknown_op", {16'd0, pc_branch}, 32'd0);
      step(); chk("unknown_no_wr", dut.regs_q[1], 32'h000000FF);

      // branches
      itype(6'h04, 5'd1, 5'd1, 16'd3);     chk("beq_taken", {16'd0, pc_branch}, 32'd16);
      itype(6'h04, 5'd1, 5'd3, 16'd3);     chk("beq_not", {16'd0, pc_branch}, 32'd0);
      itype(6'h05, 5'd1, 5'd1, 16'd3);     chk("bne_not", {16'd0, pc_branch}, 32'd0);
      itype(6'h05, 5'd1, 5'd3, 16'd1);     chk("bne_taken", {16'd0, pc_branch}, 32'd8);
      itype(6'h07, 5'd3, 5'd0, 16'd3);     chk("bgtz_neg", {16'd0, pc_branch}, 32'd0);
      itype(6'h07, 5'd1, 5'd0, 16'd2);     chk("bgtz_pos", {16'd0, pc_branch}, 32'd12);
      itype(6'h06, 5'd3, 5'd0, 16'd5);     chk("blez_neg", {16'd0, pc_branch}, 32'd24);
      itype(6'h06, 5'd0, 5'd0, 16'd0);     chk("blez_zero", {16'd0, pc_branch}, 32'd4);
      itype(6'h06, 5'd1, 5'd0, 16'd5);     chk("blez_pos", {16'd0, pc_branch}, 32'd0);
      itype(6'h04, 5'd1, 5'd1, 16'h3FFF);  chk("beq_wrap0", {16'd0, pc_branch}, 32'd0);
      itype(6'h04, 5'd1, 5'd1, 16'h4001);  chk("beq_trunc", {16'd0, pc_branch}, 32'd8);
      step(); chk("branch_no_wr", dut.regs_q[1], 32'h000000FF);

      // back-to-back dependent writes
      itype(6'h08, 5'd0, 5'd1, 16'd1); step();
      itype(6'h08, 5'd1, 5'd1, 16'd1); step(); chk("b2b_r1", dut.regs_q[1], 32'd2);

      // halt
      rtype(6'h0C, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("halt_before_edge", {31'd0, halted_signal}, 32'd0);
      step(); chk("halt_set", {31'd0, halted_signal}, 32'd1);
      itype(6'h08, 5'd1, 5'd1, 16'd1); step(); chk("halt_no_wr", dut.regs_q[1], 32'd2);
      itype(6'h04, 5'd1, 5'd1, 16'd3);
      chk("halt_pc0", {16'd0, pc_branch}, 32'd0);
      step(); chk("halt_sticky", {31'd0, halted_signal}, 32'd1);

      // reset while halted
      @(negedge clk); rst_b = 1'b1;
      step();
      chk("rst_halt_clr", {31'd0, halted_signal}, 32'd0);
      chk("rst_r1_clr", dut.regs_q[1], 32'd0);
      chk("rst_r13_clr", dut.regs_q[13], 32'd0);
      @(negedge clk); rst_b = 1'b0;
      itype(6'h08, 5'd0, 5'd1, 16'd7); step(); chk("post_rst_addi", dut.regs_q[1], 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time bound so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
